// File: rtl/spi_pkg.sv
// Shared types for the SPI receiver: FSM states and the SCK edge-role helper.
// The helper maps CKP/CPH plus raw rise/fall pulses onto sample/shift strobes.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  typedef struct packed {
    logic sample;
    logic shift;
  } edge_sel_t;

  // Leading edge leaves the idle level; CPH picks which edge samples MOSI.
  function automatic edge_sel_t edge_select(input logic ckp, input logic cph,
                                            input logic rise, input logic fall);
    edge_sel_t sel;
    logic leading;
    logic trailing;
    leading    = ckp ? fall : rise;
    trailing   = ckp ? rise : fall;
    sel.sample = cph ? trailing : leading;
    sel.shift  = cph ? leading : trailing;
    return sel;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin plus single-cycle rise/fall pulses.
// Resets to 0, so a pin already low at reset release never produces a false fall.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   level;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_receiver.sv
// SPI target: oversamples CS/SCK/MOSI on CLK, assembles MSB-first bytes and
// shifts a reply byte out on MISO, in any of the four CKP/CPH modes.
module spi_receiver
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CKP,
  input  logic              CPH,
  input  logic              CS,
  input  logic              SCK,
  input  logic              MOSI,
  input  logic [DATA_W-1:0] data_in,
  output logic              MISO,
  output logic [DATA_W-1:0] data_out,
  output logic              rx_valid,
  output logic              rx_abort
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t                 state_q;
  state_t                 state_d;
  logic                   ckp_q;
  logic                   cph_q;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_W-1:0]      rx_shift;
  logic [DATA_W-1:0]      tx_shift;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_s;
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   cs_rise;
  logic                   cs_fall;
  edge_sel_t              sel;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk   (CLK),
    .reset (RESET),
    .din   (SCK),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk   (CLK),
    .reset (RESET),
    .din   (CS),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // MOSI gets the same depth as SCK so the data bit lines up with its edge pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mosi_sync <= '0;
    end else begin
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
    end
  end

  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign sel    = edge_select(ckp_q, cph_q, sck_rise, sck_fall);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE:  if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    MISO = (state_q == ACTIVE) ? tx_shift[DATA_W-1] : 1'b0;
  end

  // CS edges take priority over SCK edges landing in the same cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ckp_q    <= 1'b0;
      cph_q    <= 1'b0;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      data_out <= '0;
      rx_valid <= 1'b0;
      rx_abort <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_abort <= 1'b0;
      if (state_q == IDLE) begin
        if (cs_fall) begin
          ckp_q    <= CKP;
          cph_q    <= CPH;
          tx_shift <= data_in;
          bit_cnt  <= '0;
          rx_shift <= '0;
        end
      end else begin
        if (cs_rise) begin
          rx_abort <= (bit_cnt != '0);
          bit_cnt  <= '0;
          rx_shift <= '0;
        end else if (sel.sample) begin
          rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
          if (bit_cnt == LAST_BIT) begin
            data_out <= {rx_shift[DATA_W-2:0], mosi_s};
            rx_valid <= 1'b1;
            bit_cnt  <= '0;
            tx_shift <= data_in;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end else if (sel.shift && (bit_cnt != '0)) begin
          // At bit_cnt 0 the MSB is held so a fresh byte is not shifted early.
          tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_receiver.sv
// Self-checking bench for spi_receiver: the bench acts as SPI master, checks MISO
// bit-by-bit and scoreboards received bytes against rx_valid pulses.
module tb_spi_receiver;

  localparam int HALF = 8;

  typedef struct {
    logic       ckp;
    logic       cph;
    logic [7:0] mosi;
    logic [7:0] reply;
    logic [7:0] exp_miso;
    logic [7:0] exp_data;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       CKP = 1'b0;
  logic       CPH = 1'b0;
  logic       CS = 1'b1;
  logic       SCK = 1'b0;
  logic       MOSI = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       MISO;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       rx_abort;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int abort_cnt = 0;
  logic [7:0] exp_q[$];

  spi_receiver #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .CKP      (CKP),
    .CPH      (CPH),
    .CS       (CS),
    .SCK      (SCK),
    .MOSI     (MOSI),
    .data_in  (data_in),
    .MISO     (MISO),
    .data_out (data_out),
    .rx_valid (rx_valid),
    .rx_abort (rx_abort)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Scoreboard: every rx_valid pulse pops one expected byte.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (rx_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rx_valid: got data_out %0h with empty scoreboard", data_out);
        end else begin
          checkOutput("scoreboard_data_out", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
        end
      end
      if (rx_abort) abort_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog");
  end

  task automatic halfWait();
    repeat (HALF) @(negedge CLK);
  endtask

  // Master frame: n_bits MSB-first from mosi_w[15]; reply bytes from reply_w.
  task automatic applyStimulus(input logic m_ckp, input logic m_cph,
                               input logic [15:0] mosi_w, input logic [15:0] reply_w,
                               input int n_bits, output logic [15:0] miso_w);
    miso_w  = '0;
    CKP     = m_ckp;
    CPH     = m_cph;
    SCK     = m_ckp;
    data_in = reply_w[15:8];
    halfWait();
    CS = 1'b0;
    halfWait();
    for (int i = 0; i < n_bits; i++) begin
      if (!m_cph) begin
        MOSI = mosi_w[15-i];
        halfWait();
        miso_w[15-i] = MISO;
        if (i % 8 == 7) exp_q.push_back(i == 7 ? mosi_w[15:8] : mosi_w[7:0]);
        SCK = ~SCK;
        halfWait();
        SCK = ~SCK;
      end else begin
        SCK  = ~SCK;
        MOSI = mosi_w[15-i];
        halfWait();
        miso_w[15-i] = MISO;
        if (i % 8 == 7) exp_q.push_back(i == 7 ? mosi_w[15:8] : mosi_w[7:0]);
        SCK = ~SCK;
        halfWait();
      end
      if (i == 0) data_in = reply_w[7:0];
    end
    halfWait();
    CS = 1'b1;
    halfWait();
  endtask

  vec_t        vecs[8];
  logic [15:0] miso_w;
  int          v0;
  int          a0;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 8'h5A, 8'hC3, 8'hC3, 8'h5A};
    vecs[2] = '{1'b0, 1'b1, 8'h01, 8'h01, 8'h01, 8'h01};
    vecs[3] = '{1'b1, 1'b0, 8'h01, 8'h01, 8'h01, 8'h01};
    vecs[4] = '{1'b0, 1'b0, 8'h01, 8'h01, 8'h01, 8'h01};
    vecs[5] = '{1'b1, 1'b1, 8'h01, 8'h01, 8'h01, 8'h01};
    vecs[6] = '{1'b0, 1'b1, 8'hE7, 8'h18, 8'h18, 8'hE7};
    vecs[7] = '{1'b1, 1'b0, 8'h3C, 8'h81, 8'h81, 8'h3C};

    repeat (4) @(negedge CLK);
    checkOutput("reset_miso", {31'h0, MISO}, 32'h0);
    checkOutput("reset_data_out", {24'h0, data_out}, 32'h0);
    checkOutput("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    checkOutput("reset_rx_abort", {31'h0, rx_abort}, 32'h0);
    RESET = 1'b0;
    halfWait();

    for (int k = 0; k < 8; k++) begin
      v0 = valid_cnt;
      a0 = abort_cnt;
      applyStimulus(vecs[k].ckp, vecs[k].cph, {vecs[k].mosi, 8'h00},
                    {vecs[k].reply, 8'h00}, 8, miso_w);
      checkOutput($sformatf("vec%0d_miso", k), {24'h0, miso_w[15:8]}, {24'h0, vecs[k].exp_miso});
      checkOutput($sformatf("vec%0d_data_out", k), {24'h0, data_out}, {24'h0, vecs[k].exp_data});
      checkOutput($sformatf("vec%0d_valid_pulses", k), valid_cnt - v0, 32'd1);
      checkOutput($sformatf("vec%0d_no_abort", k), abort_cnt - a0, 32'd0);
      checkOutput($sformatf("vec%0d_miso_idle", k), {31'h0, MISO}, 32'h0);
    end

    // Two bytes back-to-back with CS held low.
    v0 = valid_cnt;
    applyStimulus(1'b0, 1'b0, 16'h0180, 16'h55AA, 16, miso_w);
    checkOutput("b2b_miso", {16'h0, miso_w}, 32'h55AA);
    checkOutput("b2b_valid_pulses", valid_cnt - v0, 32'd2);
    checkOutput("b2b_data_out", {24'h0, data_out}, 32'h80);

    // CS rises after three bits.
    v0 = valid_cnt;
    a0 = abort_cnt;
    applyStimulus(1'b0, 1'b0, 16'hE000, 16'h0000, 3, miso_w);
    checkOutput("abort_pulses", abort_cnt - a0, 32'd1);
    checkOutput("abort_no_valid", valid_cnt - v0, 32'd0);
    checkOutput("abort_data_out_held", {24'h0, data_out}, 32'h80);

    // SCK activity with CS high must be ignored.
    v0 = valid_cnt;
    a0 = abort_cnt;
    for (int i = 0; i < 10; i++) begin
      SCK = ~SCK;
      halfWait();
    end
    checkOutput("idle_sck_no_valid", valid_cnt - v0, 32'd0);
    checkOutput("idle_sck_no_abort", abort_cnt - a0, 32'd0);
    checkOutput("idle_sck_miso", {31'h0, MISO}, 32'h0);

    // RESET in the middle of a byte, then a clean frame.
    CKP = 1'b0; CPH = 1'b0; SCK = 1'b0; data_in = 8'h3C;
    halfWait();
    CS = 1'b0;
    halfWait();
    for (int i = 0; i < 4; i++) begin
      MOSI = i[0];
      halfWait();
      SCK = 1'b1;
      halfWait();
      SCK = 1'b0;
    end
    halfWait();
    checkOutput("pre_reset_miso", {31'h0, MISO}, 32'h1);
    RESET = 1'b1;
    @(negedge CLK);
    checkOutput("midreset_miso", {31'h0, MISO}, 32'h0);
    checkOutput("midreset_data_out", {24'h0, data_out}, 32'h0);
    checkOutput("midreset_rx_valid", {31'h0, rx_valid}, 32'h0);
    checkOutput("midreset_rx_abort", {31'h0, rx_abort}, 32'h0);
    @(negedge CLK);
    RESET = 1'b0;
    halfWait();
    v0 = valid_cnt;
    a0 = abort_cnt;
    CS = 1'b1;
    halfWait();
    applyStimulus(1'b0, 1'b0, 16'h7700, 16'h9900, 8, miso_w);
    checkOutput("post_reset_miso", {24'h0, miso_w[15:8]}, 32'h99);
    checkOutput("post_reset_data_out", {24'h0, data_out}, 32'h77);
    checkOutput("post_reset_valid_pulses", valid_cnt - v0, 32'd1);
    checkOutput("post_reset_no_abort", abort_cnt - a0, 32'd0);

    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
